// File: rtl/offchip_link_rx.sv
// rtl/offchip_link_rx.sv - off-chip nibble link receiver: word FIFO, byte reassembly, toggle credits
// Optional macro OFFCHIP_LINK_RX_PARITY_EN adds i_link_par/o_par_err and 5-bit FIFO entries.
module offchip_link_rx #(
  parameter int DEPTH       = 8,
  parameter int CREDIT_GRAN = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [3:0]               i_link_nib,
  input  logic                     i_link_vld,
`ifdef OFFCHIP_LINK_RX_PARITY_EN
  input  logic                     i_link_par,
  output logic                     o_par_err,
`endif
  output logic                     o_credit_tok,
  output logic [7:0]               o_data_out,
  output logic                     o_valid_out,
  input  logic                     i_ready,
  output logic                     o_ovf_err,
  output logic [$clog2(DEPTH):0]   o_fill
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = (CREDIT_GRAN > 1) ? $clog2(CREDIT_GRAN) : 1;
`ifdef OFFCHIP_LINK_RX_PARITY_EN
  localparam int WW = 5;
`else
  localparam int WW = 4;
`endif

  typedef enum logic {S_LO = 1'b0, S_HI = 1'b1} state_t;

  logic [WW-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr, r_rd_ptr;
  logic [3:0]    r_lo;
  logic [7:0]    r_data;
  logic          r_valid, r_tok, r_ovf;
  logic [CW-1:0] r_pop_cnt;
  state_t        r_state, w_next;

  logic [PW-1:0] w_fill;
  logic          w_full, w_empty, w_pop, w_load, w_wr;
  logic [WW-1:0] w_head, w_wdata;

  assign w_fill  = r_wr_ptr - r_rd_ptr;
  assign w_full  = (w_fill == PW'(DEPTH));
  assign w_empty = (w_fill == '0);
  assign w_head  = r_mem[r_rd_ptr[AW-1:0]];
  // A full FIFO still takes a word when the head leaves in the same cycle.
  assign w_wr    = i_link_vld && (!w_full || w_pop);

`ifdef OFFCHIP_LINK_RX_PARITY_EN
  assign w_wdata = {i_link_par, i_link_nib};
`else
  assign w_wdata = i_link_nib;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_LO;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_LO: if (!w_empty) w_next = S_HI;
      S_HI: if (!w_empty && (!r_valid || i_ready)) w_next = S_LO;
      default: w_next = S_LO;
    endcase
  end

  always_comb begin
    w_pop  = 1'b0;
    w_load = 1'b0;
    case (r_state)
      S_LO: w_pop = !w_empty;
      S_HI: begin
        w_pop  = !w_empty && (!r_valid || i_ready);
        w_load = w_pop;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (w_wr) r_mem[r_wr_ptr[AW-1:0]] <= w_wdata;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_lo      <= '0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_tok     <= 1'b0;
      r_ovf     <= 1'b0;
      r_pop_cnt <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      else if (i_link_vld) r_ovf <= 1'b1;
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
        if (r_pop_cnt == CW'(CREDIT_GRAN - 1)) begin
          r_pop_cnt <= '0;
          r_tok     <= ~r_tok;
        end else begin
          r_pop_cnt <= r_pop_cnt + 1'b1;
        end
      end
      if (r_state == S_LO && w_pop) r_lo <= w_head[3:0];
      // Loading while the old byte drains keeps valid high with no bubble.
      if (w_load) begin
        r_data  <= {w_head[3:2], r_lo[3:2], w_head[1:0], r_lo[1:0]};
        r_valid <= 1'b1;
      end else if (r_valid && i_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

`ifdef OFFCHIP_LINK_RX_PARITY_EN
  logic r_par_err;
  always_ff @(posedge i_clk) begin
    if (i_rst)                  r_par_err <= 1'b0;
    else if (w_pop && !(^w_head)) r_par_err <= 1'b1;
  end
  assign o_par_err = r_par_err;
`endif

  assign o_credit_tok = r_tok;
  assign o_data_out   = r_data;
  assign o_valid_out  = r_valid;
  assign o_ovf_err    = r_ovf;
  assign o_fill       = w_fill;

endmodule

// File: tb/tb_offchip_link_rx.sv
// tb/tb_offchip_link_rx.sv - randomized self-checking bench for offchip_link_rx against a queue model
module tb_offchip_link_rx;
  localparam int DEPTH = 8;
  localparam int GRAN  = 4;
  localparam int FW    = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1, vld = 1'b0, rdy = 1'b0, par = 1'b1, bad_par = 1'b0;
  logic [3:0]    nib = '0;
  logic          credit_tok, valid_out, ovf_err, par_err;
  logic [7:0]    data_out;
  logic [FW-1:0] fill;

  offchip_link_rx #(.DEPTH(DEPTH), .CREDIT_GRAN(GRAN)) dut (
    .i_clk(clk), .i_rst(rst), .i_link_nib(nib), .i_link_vld(vld),
`ifdef OFFCHIP_LINK_RX_PARITY_EN
    .i_link_par(par), .o_par_err(par_err),
`endif
    .o_credit_tok(credit_tok), .o_data_out(data_out), .o_valid_out(valid_out),
    .i_ready(rdy), .o_ovf_err(ovf_err), .o_fill(fill)
  );
`ifndef OFFCHIP_LINK_RX_PARITY_EN
  assign par_err = 1'b0;
`endif

  int total = 0, bad = 0;

  logic [4:0] q[$];
  logic [7:0] got[$];
  logic       have_lo, m_valid, m_tok, m_ovf, m_perr;
  logic [3:0] m_lo;
  logic [7:0] m_data;
  int         m_cnt;

  function automatic logic [7:0] pair_byte(input logic [3:0] w0, input logic [3:0] w1);
    logic [7:0] b;
    b[0] = w0[0]; b[1] = w0[1]; b[4] = w0[2]; b[5] = w0[3];
    b[2] = w1[0]; b[3] = w1[1]; b[6] = w1[2]; b[7] = w1[3];
    return b;
  endfunction

  task automatic model_reset();
    q.delete(); have_lo = 0; m_valid = 0; m_data = '0; m_cnt = 0;
    m_tok = 0; m_ovf = 0; m_perr = 0; m_lo = '0;
  endtask

  task automatic step(input logic v, input logic [3:0] n, input logic r, input logic rs);
    logic pop, wr, load;
    logic [4:0] w;
    rst = rs; vld = v; nib = n; rdy = r;
    par = bad_par ? (^n) : ~(^n);
    if (valid_out && r && !rs) got.push_back(data_out);
    @(posedge clk);
    if (rs) begin
      model_reset();
    end else begin
      pop  = (q.size() > 0) && (!have_lo || !m_valid || r);
      wr   = v && ((q.size() < DEPTH) || pop);
      load = 0;
      if (pop) begin
        w = q.pop_front();
        if (!(^w)) m_perr = 1;
        if (!have_lo) begin
          m_lo = w[3:0]; have_lo = 1;
        end else begin
          m_data = pair_byte(m_lo, w[3:0]); m_valid = 1; have_lo = 0; load = 1;
        end
        m_cnt++;
        if (m_cnt == GRAN) begin m_cnt = 0; m_tok = ~m_tok; end
      end
      if (!load && m_valid && r) m_valid = 0;
      if (wr) q.push_back({par, n});
      else if (v) m_ovf = 1;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    total++;
    if ({valid_out, data_out, fill, ovf_err, credit_tok, par_err} !== 15'h0) begin
      bad++;
      $display("FAIL reset_state got=%h want=0", {valid_out, data_out, fill, ovf_err, credit_tok, par_err});
    end
  endtask

  task automatic test_single_byte();
    step(0, 0, 1, 1);
    step(1, 4'h1, 1, 0);
    step(1, 4'h0, 1, 0);
    total++;
    if (valid_out !== 1'b0) begin bad++; $display("FAIL single_early_valid got=%b want=0", valid_out); end
    step(0, 0, 1, 0);
    total++;
    if (valid_out !== 1'b1 || data_out !== 8'h01) begin
      bad++; $display("FAIL single_byte got=%b/%h want=1/01", valid_out, data_out);
    end
    step(0, 0, 1, 0);
    total++;
    if (valid_out !== 1'b0 || data_out !== 8'h01) begin
      bad++; $display("FAIL single_one_cycle got=%b/%h want=0/01", valid_out, data_out);
    end
  endtask

  task automatic test_encoding();
    logic [3:0] w0 [4] = '{4'hA, 4'h5, 4'hF, 4'h0};
    logic [7:0] exp [2] = '{8'h66, 8'h33};
    step(0, 0, 1, 1);
    got.delete();
    for (int i = 0; i < 4; i++) step(1, w0[i], 1, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0);
    for (int i = 0; i < 2; i++) begin
      total++;
      if (got.size() <= i || got[i] !== exp[i]) begin
        bad++; $display("FAIL encoding_%0d got=%h want=%h", i, (got.size() > i) ? got[i] : 8'hxx, exp[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [3:0] words[$];
    logic [7:0] exp[$];
    logic [7:0] held;
    step(0, 0, 0, 1);
    got.delete();
    for (int i = 0; i < 12; i++) begin
      words.push_back(4'($urandom_range(0, 15)));
      step(1, words[i], 0, 0);
      total++;
      if ({valid_out, data_out, fill, ovf_err, credit_tok} !== {m_valid, m_data, FW'(q.size()), m_ovf, m_tok}) begin
        bad++; $display("FAIL bp_cycle_%0d got=%h want=%h", i, {valid_out, data_out, fill, ovf_err, credit_tok},
                        {m_valid, m_data, FW'(q.size()), m_ovf, m_tok});
      end
    end
    held = pair_byte(words[0], words[1]);
    total++;
    if (fill !== FW'(DEPTH) || ovf_err !== 1'b1 || valid_out !== 1'b1 || data_out !== held) begin
      bad++; $display("FAIL bp_saturate got=%0d/%b/%b/%h want=8/1/1/%h", fill, ovf_err, valid_out, data_out, held);
    end
    for (int i = 0; i < 30; i++) step(0, 0, 1, 0);
    for (int i = 0; i + 1 < 11; i += 2) exp.push_back(pair_byte(words[i], words[i+1]));
    total++;
    if (got.size() != exp.size()) begin
      bad++; $display("FAIL bp_count got=%0d want=%0d", got.size(), exp.size());
    end
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      total++;
      if (got[i] !== exp[i]) begin bad++; $display("FAIL bp_order_%0d got=%h want=%h", i, got[i], exp[i]); end
    end
  endtask

  task automatic test_credit();
    int toggles = 0;
    logic last;
    step(0, 0, 1, 1);
    last = credit_tok;
    for (int i = 0; i < 26; i++) begin
      step(i < 16, 4'($urandom_range(0, 15)), 1, 0);
      if (credit_tok !== last) toggles++;
      last = credit_tok;
      total++;
      if ({valid_out, data_out, fill, credit_tok} !== {m_valid, m_data, FW'(q.size()), m_tok}) begin
        bad++; $display("FAIL credit_cycle_%0d got=%h want=%h", i, {valid_out, data_out, fill, credit_tok},
                        {m_valid, m_data, FW'(q.size()), m_tok});
      end
    end
    total++;
    if (toggles != 4 || credit_tok !== 1'b0) begin
      bad++; $display("FAIL credit_toggles got=%0d/%b want=4/0", toggles, credit_tok);
    end
  endtask

  task automatic test_reset_midbyte();
    step(0, 0, 1, 1);
    step(1, 4'h7, 1, 0);
    step(0, 0, 1, 1);
    total++;
    if (valid_out !== 1'b0 || fill !== '0) begin
      bad++; $display("FAIL midrst_state got=%b/%0d want=0/0", valid_out, fill);
    end
    got.delete();
    step(1, 4'h1, 1, 0);
    step(1, 4'h0, 1, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0);
    total++;
    if (got.size() != 1 || got[0] !== 8'h01 || fill !== '0) begin
      bad++; $display("FAIL midrst_byte got=%0d/%h want=1/01", got.size(), (got.size() > 0) ? got[0] : 8'hxx);
    end
  endtask

  task automatic test_random();
    step(0, 0, 1, 1);
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 9) < 7, 4'($urandom_range(0, 15)), $urandom_range(0, 1), 0);
      total++;
      if ({valid_out, data_out, fill, ovf_err, credit_tok} !== {m_valid, m_data, FW'(q.size()), m_ovf, m_tok}) begin
        bad++; $display("FAIL rand_cycle_%0d got=%h want=%h", i, {valid_out, data_out, fill, ovf_err, credit_tok},
                        {m_valid, m_data, FW'(q.size()), m_ovf, m_tok});
      end
    end
  endtask

`ifdef OFFCHIP_LINK_RX_PARITY_EN
  task automatic test_parity();
    step(0, 0, 1, 1);
    got.delete();
    bad_par = 1;
    step(1, 4'h3, 1, 0);
    bad_par = 0;
    step(1, 4'h0, 1, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0);
    total++;
    if (par_err !== 1'b1 || par_err !== m_perr || got.size() != 1 || got[0] !== pair_byte(4'h3, 4'h0)) begin
      bad++; $display("FAIL parity got=%b/%0d want=1/1", par_err, got.size());
    end
  endtask
`endif

  initial begin
    model_reset();
    @(negedge clk);
    test_reset();
    test_single_byte();
    test_encoding();
    test_backpressure();
    test_credit();
    test_reset_midbyte();
    test_random();
`ifdef OFFCHIP_LINK_RX_PARITY_EN
    test_parity();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
